// File: rtl/fc_layer_scheduler.sv
// Fully connected layer sequencer: one MAC path over a sync weight RAM, forward or weight-update pass.
// Latency start->done: N+1 (forward) / N+2 (update) edges; no backpressure, start ignored unless IDLE.
module fc_layer_scheduler #(
    parameter int WIDTH      = 16,
    parameter int INPUT_DIM  = 4,
    parameter int OUTPUT_DIM = 3,
    parameter int FRAC_BITS  = 8,
    parameter int LR_SHIFT   = 4,
    parameter int ADDR_W     = $clog2(OUTPUT_DIM*(INPUT_DIM+1))
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                mode,
    input  logic [INPUT_DIM-1:0][WIDTH-1:0]     input_data,
    input  logic [OUTPUT_DIM-1:0][WIDTH-1:0]    output_error,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_W-1:0]                   w_rd_addr,
    input  logic [WIDTH-1:0]                    w_rd_data,
    output logic                                w_wr_en,
    output logic [ADDR_W-1:0]                   w_wr_addr,
    output logic [WIDTH-1:0]                    w_wr_data,
    output logic [OUTPUT_DIM-1:0][WIDTH-1:0]    output_data
);
    localparam int N     = OUTPUT_DIM*(INPUT_DIM+1);
    localparam int J_W   = $clog2(INPUT_DIM+1);
    localparam int I_W   = $clog2(OUTPUT_DIM+1);
    localparam int ACC_W = 2*WIDTH + $clog2(INPUT_DIM+1);

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_UPD, S_DRAIN, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic                                mode_q, mode_d;
    logic [INPUT_DIM-1:0][WIDTH-1:0]     x_q, x_d;
    logic [OUTPUT_DIM-1:0][WIDTH-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]                   k_q, k_d;
    logic [I_W-1:0]                      i_q, i_d;
    logic [J_W-1:0]                      j_q, j_d;
    logic                                drain_q, drain_d;
    logic                                p1_vld_q, p1_vld_d;
    logic [I_W-1:0]                      p1_i_q, p1_i_d;
    logic [J_W-1:0]                      p1_j_q, p1_j_d;
    logic [ADDR_W-1:0]                   p1_k_q, p1_k_d;
    logic signed [ACC_W-1:0]             acc_q, acc_d;
    logic [OUTPUT_DIM-1:0][WIDTH-1:0]    out_q, out_d;
    logic                                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]                   wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]                    wr_data_q, wr_data_d;

    logic signed [ACC_W-1:0]             w_s, x_s, e_s, acc_n, delta;

    function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1:0];
        if (v > sext({1'b0, {(WIDTH-1){1'b1}}}))
            r = {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < sext({1'b1, {(WIDTH-1){1'b0}}}))
            r = {1'b1, {(WIDTH-1){1'b0}}};
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        x_d       = x_q;
        err_d     = err_q;
        k_d       = k_q;
        i_d       = i_q;
        j_d       = j_q;
        drain_d   = drain_q;
        p1_vld_d  = 1'b0;
        p1_i_d    = p1_i_q;
        p1_j_d    = p1_j_q;
        p1_k_d    = p1_k_q;
        acc_d     = acc_q;
        out_d     = out_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        w_s       = sext(w_rd_data);
        x_s       = '0;
        e_s       = '0;
        acc_n     = acc_q;
        delta     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    x_d     = input_data;
                    err_d   = output_error;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = mode ? S_UPD : S_FWD;
                end
            end
            S_FWD, S_UPD: begin
                p1_vld_d = 1'b1;
                p1_i_d   = i_q;
                p1_j_d   = j_q;
                p1_k_d   = k_q;
                if (j_q == J_W'(INPUT_DIM)) begin
                    j_d = '0;
                    i_d = i_q + I_W'(1);
                end else begin
                    j_d = j_q + J_W'(1);
                end
                if (k_q == ADDR_W'(N-1)) begin
                    k_d     = '0;
                    i_d     = '0;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            // Forward needs one cycle to absorb the last read; update one more to emit the last write.
            S_DRAIN: begin
                if (!mode_q || drain_q) state_d = S_DONE;
                else                    drain_d = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        for (int n = 0; n < INPUT_DIM; n++)
            if (int'(p1_j_q) == n + 1) x_s = sext(x_q[n]);
        for (int n = 0; n < OUTPUT_DIM; n++)
            if (int'(p1_i_q) == n) e_s = sext(err_q[n]);

        if (p1_vld_q) begin
            if (!mode_q) begin
                if (p1_j_q == '0) acc_n = w_s <<< FRAC_BITS;
                else              acc_n = acc_q + w_s * x_s;
                acc_d = acc_n;
                if (p1_j_q == J_W'(INPUT_DIM))
                    for (int n = 0; n < OUTPUT_DIM; n++)
                        if (int'(p1_i_q) == n) out_d[n] = sat(acc_n >>> FRAC_BITS);
            end else begin
                if (p1_j_q == '0) delta = e_s >>> LR_SHIFT;
                else              delta = (e_s * x_s) >>> (FRAC_BITS + LR_SHIFT);
                wr_en_d   = 1'b1;
                wr_addr_d = p1_k_q;
                wr_data_d = sat(w_s + delta);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            x_q       <= '0;
            err_q     <= '0;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            drain_q   <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_i_q    <= '0;
            p1_j_q    <= '0;
            p1_k_q    <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            err_q     <= err_d;
            k_q       <= k_d;
            i_q       <= i_d;
            j_q       <= j_d;
            drain_q   <= drain_d;
            p1_vld_q  <= p1_vld_d;
            p1_i_q    <= p1_i_d;
            p1_j_q    <= p1_j_d;
            p1_k_q    <= p1_k_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy        = (state_q == S_FWD) || (state_q == S_UPD) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign w_rd_addr   = k_q;
    assign w_wr_en     = wr_en_q;
    assign w_wr_addr   = wr_addr_q;
    assign w_wr_data   = wr_data_q;
    assign output_data = out_q;
endmodule
